// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_lock_supervisor_pkg;

    // Width of the retry counter output
    localparam int unsigned RETRY_W = 4;

    // Supervisor FSM states
    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAIL   = 3'd4
    } state_t;

    // Ceiling log2, used to size counters from their limits
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((64'd1 << width) < 64'(value)) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync.sv
// Multi-flop synchroniser bringing the asynchronous PLL locked flag into refclk.
module pll_lock_supervisor_sync
    import pll_lock_supervisor_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic refclk,
    input  logic rst,
    input  logic locked,
    output logic locked_s
);

    logic [SYNC_STAGES-1:0] sync_ff;

    // Shift the raw flag through the synchroniser chain
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], locked};
        end
    end

    assign locked_s = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses PLL reset, waits for a stable lock, then
// releases the downstream system reset. Retries on lock timeout up to
// MAX_RETRY attempts and then latches fail; lock loss in RUN restarts.
// Optional build macro PLL_LOCK_SUPERVISOR_LOSS_CNT_EN adds an 8-bit
// saturating lock-loss counter output (loss_cnt).
module pll_lock_supervisor
    import pll_lock_supervisor_pkg::*;
#(
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned PLL_RST_CYC      = 16,
    parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
    parameter int unsigned LOCK_STABLE_CYC  = 1024,
    parameter int unsigned MAX_RETRY        = 4
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               lock_ok,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
    ,
    output logic [7:0]         loss_cnt
`endif
);

    localparam int unsigned RST_W = clog2(PLL_RST_CYC) + 1;
    localparam int unsigned TMO_W = clog2(LOCK_TIMEOUT_CYC) + 1;
    localparam int unsigned STB_W = clog2(LOCK_STABLE_CYC) + 1;

    localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(PLL_RST_CYC - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [STB_W-1:0]   STB_DONE  = STB_W'(LOCK_STABLE_CYC);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    state_t             state;
    state_t             state_next;
    logic               locked_s;
    logic [RST_W-1:0]   rst_cnt;
    logic [RST_W-1:0]   rst_cnt_next;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [TMO_W-1:0]   tmo_cnt_next;
    logic [STB_W-1:0]   stb_cnt;
    logic [STB_W-1:0]   stb_cnt_next;
    logic [RETRY_W-1:0] retry_next;
    logic [RETRY_W-1:0] retry_inc;
    logic               timeout;
    logic               stable_done;
    state_t             timeout_state;
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
    logic [7:0]         loss_next;
`endif

    pll_lock_supervisor_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .refclk   (refclk),
        .rst      (rst),
        .locked   (pll_locked),
        .locked_s (locked_s)
    );

    assign timeout       = (tmo_cnt == TMO_LAST);
    assign stable_done   = locked_s && (stb_cnt == STB_DONE);
    assign retry_inc     = retry_cnt + RETRY_W'(1);
    assign timeout_state = (retry_inc == RETRY_MAX) ? S_FAIL : S_RESET;

    // State, counter and retry registers
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state     <= S_RESET;
            rst_cnt   <= '0;
            tmo_cnt   <= '0;
            stb_cnt   <= '0;
            retry_cnt <= '0;
        end else begin
            state     <= state_next;
            rst_cnt   <= rst_cnt_next;
            tmo_cnt   <= tmo_cnt_next;
            stb_cnt   <= stb_cnt_next;
            retry_cnt <= retry_next;
        end
    end

    // Next-state and counter update; stable completion beats a same-cycle timeout
    always_comb begin
        state_next   = state;
        rst_cnt_next = '0;
        tmo_cnt_next = tmo_cnt;
        stb_cnt_next = stb_cnt;
        retry_next   = retry_cnt;
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
        loss_next    = loss_cnt;
`endif
        case (state)
            S_RESET: begin
                if (rst_cnt == RST_LAST) begin
                    state_next   = S_WAIT;
                    tmo_cnt_next = '0;
                    stb_cnt_next = '0;
                end else begin
                    rst_cnt_next = rst_cnt + RST_W'(1);
                end
            end
            S_WAIT: begin
                tmo_cnt_next = tmo_cnt + TMO_W'(1);
                if (timeout) begin
                    state_next   = timeout_state;
                    retry_next   = retry_inc;
                    tmo_cnt_next = '0;
                    stb_cnt_next = '0;
                end else if (locked_s) begin
                    state_next   = S_STABLE;
                    stb_cnt_next = STB_W'(1);
                end
            end
            S_STABLE: begin
                tmo_cnt_next = tmo_cnt + TMO_W'(1);
                if (stable_done) begin
                    state_next   = S_RUN;
                    tmo_cnt_next = '0;
                    stb_cnt_next = '0;
                end else if (timeout) begin
                    state_next   = timeout_state;
                    retry_next   = retry_inc;
                    tmo_cnt_next = '0;
                    stb_cnt_next = '0;
                end else if (locked_s) begin
                    stb_cnt_next = stb_cnt + STB_W'(1);
                end else begin
                    state_next   = S_WAIT;
                    stb_cnt_next = '0;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_next = S_RESET;
                    retry_next = '0;
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
                    loss_next  = (loss_cnt == 8'hFF) ? loss_cnt : loss_cnt + 8'd1;
`endif
                end
            end
            S_FAIL: begin
                state_next = S_FAIL;
            end
            default: begin
                state_next = S_RESET;
            end
        endcase
    end

    // Outputs are flopped from the next-state decode so they track the state register exactly
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            pll_rst <= 1'b1;
            sys_rst <= 1'b1;
            lock_ok <= 1'b0;
            fail    <= 1'b0;
        end else begin
            pll_rst <= (state_next == S_RESET);
            sys_rst <= (state_next != S_RUN);
            lock_ok <= (state_next == S_RUN);
            fail    <= (state_next == S_FAIL);
        end
    end

`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
    // Lock-loss counter, cleared only by rst
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            loss_cnt <= '0;
        end else begin
            loss_cnt <= loss_next;
        end
    end
`endif

endmodule
